wma_filter_param: RTL

//   Parametrised weighted moving-average FIR for the sample datapath; next generation of the fixed 4-tap filter.

---
 rtl/wma_filter_param_if.sv | 26 ++
 rtl/wma_filter_param.sv | 123 ++++++++++++
 2 files changed

// File: rtl/wma_filter_param_if.sv
// Stream, control and status signals of the weighted moving-average filter.
// The filter connects through the slave modport; the sample source/sink side uses master.
interface wma_filter_param_if #(
  parameter int unsigned DATA_W = 8
) ();
  logic              clear;
  logic              mode;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] data_in;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] data_out;
  logic              primed;
  logic              sat;

  modport master (
    output clear, mode, in_valid, data_in, out_ready,
    input  in_ready, out_valid, data_out, primed, sat
  );

  modport slave (
    input  clear, mode, in_valid, data_in, out_ready,
    output in_ready, out_valid, data_out, primed, sat
  );
endinterface

// File: rtl/wma_filter_param.sv
// Parametrised weighted moving-average FIR with valid/ready handshake, warm-up flag and saturation.
// Optional WMA_ROUND_EN: every right shift rounds half-up instead of truncating.
module wma_filter_param #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned TAPS   = 4,
  parameter int unsigned CNT_W  = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  wma_filter_param_if.slave    bus
);

  localparam int unsigned LOG2_TAPS = $clog2(TAPS);
  localparam int unsigned ACC_W     = DATA_W + 2;
  localparam int unsigned SUM_W     = DATA_W + LOG2_TAPS;
  localparam int unsigned HIST_N    = TAPS - 1;
  localparam logic [DATA_W-1:0] MAX_VAL = '1;

  logic [DATA_W-1:0] hist_q [HIST_N];
  logic [DATA_W-1:0] hist_d [HIST_N];
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              ovalid_q, ovalid_d;
  logic              sat_q, sat_d;
  logic              primed_q, primed_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [DATA_W-1:0] samples [TAPS];
  logic [ACC_W-1:0]  wsum, tap_v;
  logic [SUM_W-1:0]  usum;
  logic [DATA_W-1:0] result_c;
  logic              result_sat_c;
  logic              accept_c;

  assign bus.in_ready  = !ovalid_q || bus.out_ready;
  assign accept_c      = bus.in_valid && bus.in_ready && !bus.clear;
  assign bus.data_out  = dout_q;
  assign bus.out_valid = ovalid_q;
  assign bus.sat       = sat_q;
  assign bus.primed    = primed_q;

  // Filter arithmetic over the incoming sample plus the stored history.
  always_comb begin
    samples[0] = bus.data_in;
    for (int k = 1; k < TAPS; k++) samples[k] = hist_q[k-1];

    wsum  = '0;
    tap_v = '0;
    for (int k = 0; k < TAPS; k++) begin
      if (k < DATA_W) begin
        tap_v = ACC_W'(samples[k]);
`ifdef WMA_ROUND_EN
        // Half of 2**k is zero for the unshifted tap, so it needs no special case.
        tap_v = tap_v + ((ACC_W'(1) << k) >> 1);
`endif
        wsum = wsum + (tap_v >> k);
      end
    end

    usum = '0;
    for (int k = 0; k < TAPS; k++) usum = usum + SUM_W'(samples[k]);
`ifdef WMA_ROUND_EN
    usum = usum + SUM_W'(TAPS / 2);
`endif

    result_c     = DATA_W'(usum >> LOG2_TAPS);
    result_sat_c = 1'b0;
    if (!bus.mode) begin
      if (wsum > ACC_W'(MAX_VAL)) begin
        result_c     = MAX_VAL;
        result_sat_c = 1'b1;
      end else begin
        result_c = DATA_W'(wsum);
      end
    end
  end

  // Next state: clear wins over accept, accept wins over beat completion.
  always_comb begin
    hist_d   = hist_q;
    dout_d   = dout_q;
    ovalid_d = ovalid_q;
    sat_d    = sat_q;
    primed_d = primed_q;
    cnt_d    = cnt_q;
    if (bus.clear) begin
      for (int k = 0; k < HIST_N; k++) hist_d[k] = '0;
      dout_d   = '0;
      ovalid_d = 1'b0;
      sat_d    = 1'b0;
      primed_d = 1'b0;
      cnt_d    = '0;
    end else if (accept_c) begin
      hist_d[0] = bus.data_in;
      for (int k = 1; k < HIST_N; k++) hist_d[k] = hist_q[k-1];
      dout_d   = result_c;
      sat_d    = result_sat_c;
      ovalid_d = 1'b1;
      if (cnt_q != CNT_W'(TAPS)) cnt_d = cnt_q + CNT_W'(1);
      primed_d = (cnt_d == CNT_W'(TAPS));
    end else if (ovalid_q && bus.out_ready) begin
      ovalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < HIST_N; k++) hist_q[k] <= '0;
      dout_q   <= '0;
      ovalid_q <= 1'b0;
      sat_q    <= 1'b0;
      primed_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      hist_q   <= hist_d;
      dout_q   <= dout_d;
      ovalid_q <= ovalid_d;
      sat_q    <= sat_d;
      primed_q <= primed_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule
